// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, fed LSB-first
// from operand shift registers, with valid/ready handshakes on both sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, ps_q, sum_q;
    logic [WIDTH-1:0] ps_d;
    logic             c_q, cout_q;
    logic             s_bit, c_bit;
    logic [CW-1:0]    cnt_q;

    // Full-adder cell; the new sum bit enters the partial sum from the MSB end.
    always_comb begin
        s_bit           = a_q[0] ^ b_q[0] ^ c_q;
        c_bit           = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (a_q[0] & c_q);
        ps_d            = ps_q >> 1;
        ps_d[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    ps_q  <= ps_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_bit;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= ps_d;
                        cout_q  <= c_bit;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH = 8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int acc_mon = 0;
    int res_mon = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_mon++;
        if (out_valid && out_ready) res_mon++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns right after the accept edge.
    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_result(input logic [7:0] es, input logic ec, input bit churn);
        int k  = 0;
        int bc = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && k < 20) begin
            if (busy) bc++;
            if (churn) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                cin = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
        check("latency", k, 8);
        check("busy_cycles", bc, 8);
        check("sum", sum, es);
        check("cout", cout, ec);
    endtask

    task automatic finish_op();
        @(negedge clk);
        check("handoff_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;
        int         stall;
        int         ov_seen;
        int         acc0, res0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add
        out_ready = 1'b1;
        start_op(8'h5A, 8'h33, 1'b0);
        wait_result(8'h8D, 1'b0, 1'b0);
        finish_op();

        // Carry chain
        start_op(8'hFF, 8'h01, 1'b0);
        wait_result(8'h00, 1'b1, 1'b0);
        finish_op();
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_result(8'hFF, 1'b1, 1'b0);
        finish_op();

        // Backpressure with a pending new request
        out_ready = 1'b0;
        start_op(8'h01, 8'h02, 1'b0);
        wait_result(8'h03, 1'b0, 1'b0);
        acc0 = acc_mon;
        repeat (5) begin
            a        = 8'h77;
            b        = 8'h11;
            cin      = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", sum, 8'h03);
            check("bp_cout", cout, 0);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_no_accept", acc_mon - acc0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        start_op(8'h77, 8'h11, 1'b1);
        wait_result(8'h89, 1'b0, 1'b0);
        finish_op();

        // Operand churn during SHIFT
        start_op(8'h80, 8'h80, 1'b1);
        wait_result(8'h01, 1'b1, 1'b1);
        finish_op();

        // Reset after 3 SHIFT cycles
        start_op(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("aborted_no_out_valid", ov_seen, 0);
        start_op(8'h10, 8'h0F, 1'b0);
        wait_result(8'h1F, 1'b0, 1'b0);
        finish_op();

        // Randomized sweep with output stalls
        acc0 = acc_mon;
        res0 = res_mon;
        for (int i = 0; i < 1000; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rc    = 1'($urandom);
            exp9  = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            start_op(ra, rb, rc);
            wait_result(exp9[7:0], exp9[8], 1'b0);
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            finish_op();
        end
        check("sweep_accepts", acc_mon - acc0, 1000);
        check("sweep_results", res_mon - res0, acc_mon - acc0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands plus a carry-in over WIDTH clock cycles. It uses a single full-adder cell (Sum = A^B^C, Carry = majority(A,B,C)) and a registered carry. It sits in front of the full-adder datapath as the sequencing stage: it accepts operands on a valid/ready handshake, feeds one bit pair per cycle LSB-first through the cell, and presents the assembled result on a second valid/ready handshake.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits [WIDTH-1:0].
- cout  output  1  result bit WIDTH (final carry).
- busy  output  1  high while in state SHIFT.

## Operation
- The block has three states: IDLE, SHIFT and DONE.
- in_ready = (state == IDLE). busy = (state == SHIFT). out_valid = (state == DONE).
- **IDLE:** an edge with in_valid && in_ready is an accept. On an accept the block:
  - loads a and b into operand shift registers;
  - sets carry register = cin;
  - sets bit counter = 0;
  - moves to SHIFT.
- **SHIFT:** each edge does the following:
  - Takes operand LSBs x, y and carry c.
  - Computes s = x^y^c and c' = (x&y)|(y&c)|(x&c).
  - Shifts s into the MSB of the partial-sum register.
  - Right-shifts both operand registers and sets carry = c'.
  - Increments the counter.
- SHIFT ends on the edge that processes bit WIDTH-1. That edge copies the completed partial sum to sum, copies c' to cout, and moves to DONE.
- **DONE:** an edge with out_ready high moves to IDLE. While out_ready is low, the block stays in DONE.
- sum and cout change only on the SHIFT→DONE edge. They hold the last result indefinitely, including through IDLE and the next SHIFT.
- Arithmetic: {cout, sum} = a + b + cin, computed exactly at WIDTH+1 bits with no truncation. The operands used are those captured at the accept edge.
- The block ignores changes on a, b and cin outside the accept edge.
- in_valid asserted during SHIFT or DONE causes no transfer; the source must hold it.
- out_ready asserted outside DONE has no effect.
- There is no overlap between operations: a new accept requires a return to IDLE first.

## Timing
- Reset (rst_n low, asynchronous) puts the block in:
  - state IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - busy = 0;
  - sum = 0;
  - cout = 0;
  - counter, carry and shift registers = 0.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. For WIDTH = 1, this is the first edge after the accept.
- Minimum period between accepts is WIDTH+2 cycles: WIDTH SHIFT cycles, 1 DONE cycle with out_ready high, and 1 IDLE cycle.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation and discards the result. out_valid does not assert for it. in_ready is 1 immediately, while rst_n is low.
- Handshakes follow these rules:
  - Both handshakes use the standard valid/ready rule: a transfer happens on an edge where both signals are high.
  - out_valid, sum and cout are stable until the transfer.
  - out_valid does not depend combinationally on out_ready.

## Test plan
All scenarios use WIDTH = 8.
- Basic add: a=8'h5A, b=8'h33, cin=0, out_ready held 1. Required: sum=8'h8D, cout=0; out_valid rises exactly 8 edges after the accept; busy is high for 8 cycles.
- Carry chain: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with new operands meanwhile. Required: out_valid, sum and cout stable; in_ready=0; no accept. After out_ready=1, the block returns to IDLE and the new operands are accepted on the next edge.
- Operand churn: change a, b and cin every cycle during SHIFT. Required: the result matches the values captured at the accept edge (a=8'h80, b=8'h80, cin=1 → sum=8'h01, cout=1).
- Reset mid-operation: assert rst_n low after 3 SHIFT cycles. Required: all outputs at reset values, out_valid never rises for that operation. A following accept with a=8'h10, b=8'h0F, cin=0 yields sum=8'h1F, cout=0 with normal latency.
- Sweep: random operand and cin sequences (≥1000) with random out_ready stalls. Each result is checked against a+b+cin, and the number of results equals the number of accepts.
